// File: rtl/alu_accumulator_if.sv
// Operand/result handshake bundle for alu_accumulator.
//   master: operand source and result consumer (drives in_valid, op, a, b,
//           use_acc, acc_clr, out_ready; observes in_ready and the result side)
//   slave : the ALU (drives in_ready, out_valid, result, result_hi and flags)
interface alu_accumulator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             use_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             dbz;

  modport master (
    output in_valid, op, a, b, use_acc, acc_clr, out_ready,
    input  in_ready, out_valid, result, result_hi, carry, overflow, zero, dbz
  );

  modport slave (
    input  in_valid, op, a, b, use_acc, acc_clr, out_ready,
    output in_ready, out_valid, result, result_hi, carry, overflow, zero, dbz
  );
endinterface

// File: rtl/alu_accumulator.sv
// ALU with accumulator for the calculator core.
// Single-cycle ADD/SUB/OR/AND/XOR/EQ, iterative WIDTH-step MUL (shift-add) and
// DIV (restoring). Results can be chained through the accumulator.
// Ports:
//   clk  - clock, all registers update on posedge
//   rst  - synchronous active-high reset
//   bus  - alu_accumulator_if.slave: operand handshake (in_valid/in_ready, op,
//          a, b, use_acc, acc_clr) and result handshake (out_valid/out_ready,
//          result, result_hi, carry, overflow, zero, dbz)
module alu_accumulator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_accumulator_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_EQ, OP_MUL, OP_DIV
  } op_e;

  state_e           state;
  logic             in_ready_r, out_valid_r;
  logic [WIDTH-1:0] result_r, result_hi_r;
  logic             carry_r, overflow_r, zero_r, dbz_r;
  logic [WIDTH-1:0] acc;

  // Iterative datapath: hi = partial product / remainder,
  // lo = multiplier / quotient, mcand = multiplicand / divisor.
  logic [WIDTH-1:0] hi, lo, mcand;
  logic             is_div;
  logic [CW-1:0]    cnt;

  // Single-cycle operation results
  op_e              op_in;
  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] s_res;
  logic             s_carry, s_ovf;

  // One iteration of MUL / DIV
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign op_in = op_e'(bus.op);

  always_comb begin
    opa      = bus.use_acc ? acc : bus.a;
    sum_ext  = {1'b0, opa} + {1'b0, bus.b};
    diff_ext = {1'b0, opa} - {1'b0, bus.b};
    s_res    = '0;
    s_carry  = 1'b0;
    s_ovf    = 1'b0;
    case (op_in)
      OP_ADD: begin
        s_res   = sum_ext[WIDTH-1:0];
        s_carry = sum_ext[WIDTH];
        s_ovf   = (opa[WIDTH-1] == bus.b[WIDTH-1]) && (s_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        s_res   = diff_ext[WIDTH-1:0];
        s_carry = diff_ext[WIDTH];  // borrow
        s_ovf   = (opa[WIDTH-1] != bus.b[WIDTH-1]) && (s_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_OR:   s_res = opa | bus.b;
      OP_AND:  s_res = opa & bus.b;
      OP_XOR:  s_res = opa ^ bus.b;
      OP_EQ:   s_res = WIDTH'(opa == bus.b);
      default: s_res = '0;
    endcase
  end

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_sh  = {hi, lo[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, mcand};
    // When div_ge holds the difference is below mcand, so WIDTH bits suffice.
    div_sub = div_sh[WIDTH-1:0] - mcand;
    if (is_div) begin
      step_hi = div_ge ? div_sub : div_sh[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      result_hi_r <= '0;
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      dbz_r       <= 1'b0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      mcand       <= '0;
      is_div      <= 1'b0;
      cnt         <= '0;
    end else begin
      // A result load later in this block overrides the clear.
      if (bus.acc_clr) acc <= '0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            if (op_in == OP_MUL || op_in == OP_DIV) begin
              state  <= BUSY;
              is_div <= (op_in == OP_DIV);
              hi     <= '0;
              lo     <= (op_in == OP_DIV) ? opa : bus.b;
              mcand  <= (op_in == OP_DIV) ? bus.b : opa;
              cnt    <= CW'(WIDTH);
            end else begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              result_r    <= s_res;
              result_hi_r <= '0;
              carry_r     <= s_carry;
              overflow_r  <= s_ovf;
              zero_r      <= (s_res == '0);
              dbz_r       <= 1'b0;
              acc         <= s_res;
            end
          end
        end
        BUSY: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            result_r    <= step_lo;
            result_hi_r <= step_hi;
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= (step_lo == '0);
            // Divide-by-zero needs no special path: every trial subtract
            // succeeds (quotient all ones) and the remainder shifts in A.
            dbz_r       <= is_div && (mcand == '0);
            acc         <= step_lo;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.result_hi = result_hi_r;
  assign bus.carry     = carry_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
  assign bus.dbz       = dbz_r;
endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator (WIDTH=8): directed cases followed by
// randomized operations checked against an arithmetic reference model.
module tb_alu_accumulator;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_m    = 0;

  always #5 clk = ~clk;

  alu_accumulator_if #(.WIDTH(8)) bus ();
  alu_accumulator #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int res; int hi; int c; int v; int z; int d;
  } exp_t;

  function automatic int to_signed8(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic exp_t model(input int o, input int av, input int bv);
    exp_t e;
    int   r;
    e = '{0, 0, 0, 0, 0, 0};
    case (o)
      0: begin
        e.res = (av + bv) % 256;
        e.c   = (av + bv > 255) ? 1 : 0;
        r     = to_signed8(av) + to_signed8(bv);
        e.v   = (r > 127 || r < -128) ? 1 : 0;
      end
      1: begin
        e.res = (av - bv + 256) % 256;
        e.c   = (av < bv) ? 1 : 0;
        r     = to_signed8(av) - to_signed8(bv);
        e.v   = (r > 127 || r < -128) ? 1 : 0;
      end
      2: e.res = av | bv;
      3: e.res = av & bv;
      4: e.res = av ^ bv;
      5: e.res = (av == bv) ? 1 : 0;
      6: begin
        e.res = (av * bv) % 256;
        e.hi  = (av * bv) / 256;
      end
      default: begin
        if (bv == 0) begin
          e.res = 255; e.hi = av; e.d = 1;
        end else begin
          e.res = av / bv; e.hi = av % bv;
        end
      end
    endcase
    e.z = (e.res == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One full transaction: accept, latency, outputs, optional backpressure, release.
  task automatic run_op(input int o, input int av, input int bv, input bit ua,
                        input bit clr, input int hold);
    exp_t e;
    int   k;
    logic [7:0] r0, h0;
    e = model(o, ua ? acc_m : av, bv);
    bus.op = 3'(o); bus.a = 8'(av); bus.b = 8'(bv);
    bus.use_acc = ua; bus.acc_clr = clr; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    tick();
    // Unrelated requests while not IDLE must be ignored.
    bus.op = 3'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    bus.use_acc = 1'($urandom);
    k = 1;
    while (!bus.out_valid && k < 40) begin
      tick();
      k++;
    end
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    chk("latency", 32'(k), (o >= 6) ? 9 : 1);
    chk("result", 32'(bus.result), 32'(e.res));
    chk("result_hi", 32'(bus.result_hi), 32'(e.hi));
    chk("carry", 32'(bus.carry), 32'(e.c));
    chk("overflow", 32'(bus.overflow), 32'(e.v));
    chk("zero", 32'(bus.zero), 32'(e.z));
    chk("dbz", 32'(bus.dbz), 32'(e.d));
    chk("in_ready_done", 32'(bus.in_ready), 0);
    acc_m = e.res;
    r0 = bus.result; h0 = bus.result_hi;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_ready", 32'(bus.in_ready), 0);
      chk("hold_result", 32'({bus.result_hi, bus.result}), 32'({h0, r0}));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 0);
    chk("release_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.use_acc = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_outputs", 32'({bus.result_hi, bus.result}), 0);
    chk("rst_flags", 32'({bus.carry, bus.overflow, bus.zero, bus.dbz}), 0);

    run_op(0, 200, 100, 0, 0, 0);
    chk("add_spec", 32'({bus.carry, bus.overflow, bus.result}), 32'({1'b1, 1'b0, 8'd44}));
    run_op(1, 5, 7, 0, 0, 0);
    chk("sub_spec", 32'({bus.carry, bus.overflow, bus.result}), 32'({1'b1, 1'b0, 8'hFE}));
    run_op(0, 8'h7F, 8'h01, 0, 0, 0);
    chk("add_ovf_spec", 32'({bus.overflow, bus.result}), 32'({1'b1, 8'h80}));
    run_op(6, 15, 17, 0, 0, 0);
    chk("mul_spec", 32'({bus.result_hi, bus.result}), 32'h00FF);
    run_op(6, 255, 255, 0, 0, 0);
    chk("mul_max_spec", 32'({bus.result_hi, bus.result}), 32'hFE01);
    run_op(7, 100, 7, 0, 0, 0);
    chk("div_spec", 32'({bus.dbz, bus.result_hi, bus.result}), 32'({1'b0, 8'd2, 8'd14}));
    run_op(7, 100, 0, 0, 0, 0);
    chk("dbz_spec", 32'({bus.dbz, bus.result_hi, bus.result}), 32'({1'b1, 8'd100, 8'hFF}));

    // Chaining through the accumulator
    run_op(0, 5, 0, 0, 0, 0);
    run_op(0, 0, 3, 1, 0, 0);
    chk("chain_spec", 32'(bus.result), 8);

    // Clear with no load pending
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    acc_m = 0;
    run_op(0, 99, 0, 1, 0, 0);
    chk("clr_spec", 32'({bus.zero, bus.result}), 32'({1'b1, 8'd0}));

    // Clear coincident with a load: the load wins
    run_op(0, 9, 4, 0, 1, 0);
    run_op(0, 0, 0, 1, 0, 0);
    chk("clr_vs_load", 32'(bus.result), 13);
    run_op(6, 6, 7, 0, 1, 0);
    run_op(0, 0, 1, 1, 0, 0);
    chk("clr_vs_mul_load", 32'(bus.result), 43);

    // Backpressure
    run_op(6, 12, 12, 0, 0, 5);
    run_op(1, 3, 3, 0, 0, 5);

    // Reset mid-multiply
    bus.op = 3'd6; bus.a = 8'd13; bus.b = 8'd11; bus.use_acc = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_m = 0;
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_ready", 32'(bus.in_ready), 1);
    chk("midrst_result", 32'({bus.result_hi, bus.result}), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus.out_valid) seen++;
      end
      chk("midrst_no_output", 32'(seen), 0);
    end
    run_op(0, 77, 0, 1, 0, 0);
    chk("midrst_acc", 32'(bus.result), 0);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      int o;
      o = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) begin
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
        acc_m = 0;
      end
      run_op(o, $urandom_range(0, 255),
             ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
